// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, decodes op/funct,
// drives datapath selects/enables, stalls on memory ready and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic [1:0]       RegDst,
    output logic             ALUSrc,
    output logic [2:0]       ALUop,
    output logic [1:0]       EXTop,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       Data,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW,
        I_BEQ, I_LUI, I_J, I_JAL, I_ILL
    } instr_t;

    state_t state_q, state_d;
    instr_t instr;
    logic   retire;

    always_comb begin
        instr = I_ILL;
        unique case (op)
            6'h00: begin
                unique case (funct)
                    6'h21:   instr = I_ADDU;
                    6'h23:   instr = I_SUBU;
                    6'h08:   instr = I_JR;
                    6'h00:   instr = I_NOP;
                    default: instr = I_ILL;
                endcase
            end
            6'h0D:   instr = I_ORI;
            6'h23:   instr = I_LW;
            6'h2B:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h0F:   instr = I_LUI;
            6'h02:   instr = I_J;
            6'h03:   instr = I_JAL;
            default: instr = I_ILL;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        retire   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_sel  = 2'd0;
        RegDst   = 2'd0;
        ALUSrc   = 1'b0;
        ALUop    = 3'd0;
        EXTop    = 2'd0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        Data     = 2'd0;
        illegal  = 1'b0;

        // ALU/EXT selects are set up in EXEC and held through MEM and WB.
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            unique case (instr)
                I_ADDU:       ALUop = 3'd0;
                I_SUBU:       ALUop = 3'd1;
                I_ORI:        begin ALUSrc = 1'b1; EXTop = 2'd0; ALUop = 3'd2; end
                I_LW, I_SW:   begin ALUSrc = 1'b1; EXTop = 2'd1; ALUop = 3'd0; end
                I_BEQ:        begin ALUop = 3'd1; EXTop = 2'd1; end
                default:      ;
            endcase
        end

        unique case (state_q)
            S_FETCH: begin
                if (im_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                unique case (instr)
                    I_NOP: begin pc_we = 1'b1; retire = 1'b1; end
                    I_J:   begin pc_we = 1'b1; npc_sel = 2'd2; retire = 1'b1; end
                    I_JAL: begin
                        RegWrite = 1'b1; RegDst = 2'd2; Data = 2'd3;
                        pc_we = 1'b1; npc_sel = 2'd2; retire = 1'b1;
                    end
                    I_JR:  begin pc_we = 1'b1; npc_sel = 2'd3; retire = 1'b1; end
                    I_LUI: state_d = S_WB;
                    I_ILL: begin illegal = 1'b1; pc_we = 1'b1; end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (instr)
                    I_BEQ: begin
                        pc_we   = 1'b1;
                        npc_sel = zero ? 2'd1 : 2'd0;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_LW, I_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (instr == I_SW) begin
                    MemWrite = 1'b1;
                    if (dm_ready) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (instr == I_LW) begin
                    if (dm_ready) state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                unique case (instr)
                    I_ORI:   RegDst = 2'd1;
                    I_LW:    begin RegDst = 2'd1; Data = 2'd1; end
                    I_LUI:   begin RegDst = 2'd1; EXTop = 2'd2; Data = 2'd2; end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // Reset is synchronous, so strobes must be squashed combinationally during the reset cycle.
        if (reset) begin
            state_d  = S_FETCH;
            retire   = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            npc_sel  = 2'd0;
            RegDst   = 2'd0;
            ALUSrc   = 1'b0;
            ALUop    = 3'd0;
            EXTop    = 2'd0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Data     = 2'd0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (reset) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; a second instance with CNT_W=4 checks counter wrap.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, im_ready, dm_ready;
    logic        ir_we, pc_we, RegWrite, MemWrite, ALUSrc, illegal;
    logic [1:0]  npc_sel, RegDst, EXTop, Data;
    logic [2:0]  ALUop, state;
    logic [31:0] retired;

    logic        ir_we4, pc_we4, RegWrite4, MemWrite4, ALUSrc4, illegal4;
    logic [1:0]  npc_sel4, RegDst4, EXTop4, Data4;
    logic [2:0]  ALUop4, state4;
    logic [3:0]  retired4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready), .ir_we(ir_we), .pc_we(pc_we),
        .npc_sel(npc_sel), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUop(ALUop),
        .EXTop(EXTop), .RegWrite(RegWrite), .MemWrite(MemWrite), .Data(Data),
        .state(state), .retired(retired), .illegal(illegal)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready), .ir_we(ir_we4), .pc_we(pc_we4),
        .npc_sel(npc_sel4), .RegDst(RegDst4), .ALUSrc(ALUSrc4), .ALUop(ALUop4),
        .EXTop(EXTop4), .RegWrite(RegWrite4), .MemWrite(MemWrite4), .Data(Data4),
        .state(state4), .retired(retired4), .illegal(illegal4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are then changed and outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // FETCH cycle for a new instruction: present IR fields, expect ir_we, move to DECODE.
    task automatic fetch(input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        #1;
        chk("fetch_state", 32'(state), 32'd0);
        chk("fetch_ir_we", 32'(ir_we), 32'd1);
        cyc();
    endtask

    initial begin
        reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0;
        im_ready = 1'b0; dm_ready = 1'b0;
        #1;
        chk("rst_cycle_pc_we", 32'(pc_we), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // Idle in FETCH while instruction memory is not ready
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_ir_we", 32'(ir_we), 32'd0);
            chk("idle_pc_we", 32'(pc_we), 32'd0);
            chk("idle_retired", retired, 32'd0);
            cyc();
        end

        im_ready = 1'b1; dm_ready = 1'b1;

        // addu: FETCH DECODE EXEC WB
        fetch(6'h00, 6'h21);
        chk("addu_dec_state", 32'(state), 32'd1);
        chk("addu_dec_pc_we", 32'(pc_we), 32'd0);
        cyc();
        chk("addu_exec_state", 32'(state), 32'd2);
        chk("addu_exec_alusrc", 32'(ALUSrc), 32'd0);
        chk("addu_exec_aluop", 32'(ALUop), 32'd0);
        cyc();
        chk("addu_wb_state", 32'(state), 32'd4);
        chk("addu_wb_regwrite", 32'(RegWrite), 32'd1);
        chk("addu_wb_regdst", 32'(RegDst), 32'd0);
        chk("addu_wb_data", 32'(Data), 32'd0);
        chk("addu_wb_pc_we", 32'(pc_we), 32'd1);
        cyc();
        chk("addu_retired", retired, 32'd1);

        // ori 0x00FF
        fetch(6'h0D, 6'h3F);
        cyc();
        chk("ori_exec_alusrc", 32'(ALUSrc), 32'd1);
        chk("ori_exec_aluop", 32'(ALUop), 32'd2);
        chk("ori_exec_extop", 32'(EXTop), 32'd0);
        cyc();
        chk("ori_wb_regdst", 32'(RegDst), 32'd1);
        chk("ori_wb_aluop", 32'(ALUop), 32'd2);
        chk("ori_wb_regwrite", 32'(RegWrite), 32'd1);
        cyc();
        chk("ori_retired", retired, 32'd2);

        // sw with dm_ready low for two MEM cycles
        dm_ready = 1'b0;
        fetch(6'h2B, 6'h00);
        cyc();
        chk("sw_exec_extop", 32'(EXTop), 32'd1);
        chk("sw_exec_memwrite", 32'(MemWrite), 32'd0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("sw_stall_state", 32'(state), 32'd3);
            chk("sw_stall_memwrite", 32'(MemWrite), 32'd1);
            chk("sw_stall_pc_we", 32'(pc_we), 32'd0);
            cyc();
        end
        dm_ready = 1'b1;
        #1;
        chk("sw_done_memwrite", 32'(MemWrite), 32'd1);
        chk("sw_done_regwrite", 32'(RegWrite), 32'd0);
        chk("sw_done_pc_we", 32'(pc_we), 32'd1);
        chk("sw_done_npc_sel", 32'(npc_sel), 32'd0);
        cyc();
        chk("sw_retired", retired, 32'd3);
        chk("sw_after_memwrite", 32'(MemWrite), 32'd0);

        // beq taken
        zero = 1'b1;
        fetch(6'h04, 6'h00);
        cyc();
        chk("beq1_aluop", 32'(ALUop), 32'd1);
        chk("beq1_pc_we", 32'(pc_we), 32'd1);
        chk("beq1_npc_sel", 32'(npc_sel), 32'd1);
        cyc();
        chk("beq1_retired", retired, 32'd4);

        // beq not taken
        zero = 1'b0;
        fetch(6'h04, 6'h00);
        cyc();
        chk("beq0_npc_sel", 32'(npc_sel), 32'd0);
        chk("beq0_pc_we", 32'(pc_we), 32'd1);
        cyc();
        chk("beq0_retired", retired, 32'd5);

        // jal completes in DECODE
        fetch(6'h03, 6'h00);
        chk("jal_regwrite", 32'(RegWrite), 32'd1);
        chk("jal_regdst", 32'(RegDst), 32'd2);
        chk("jal_data", 32'(Data), 32'd3);
        chk("jal_npc_sel", 32'(npc_sel), 32'd2);
        chk("jal_pc_we", 32'(pc_we), 32'd1);
        cyc();
        chk("jal_retired", retired, 32'd6);

        // illegal opcode
        fetch(6'h3F, 6'h00);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_pc_we", 32'(pc_we), 32'd1);
        chk("ill_npc_sel", 32'(npc_sel), 32'd0);
        cyc();
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_retired", retired, 32'd6);

        // lui goes DECODE -> WB
        fetch(6'h0F, 6'h00);
        chk("lui_dec_pc_we", 32'(pc_we), 32'd0);
        cyc();
        chk("lui_wb_state", 32'(state), 32'd4);
        chk("lui_wb_extop", 32'(EXTop), 32'd2);
        chk("lui_wb_data", 32'(Data), 32'd2);
        chk("lui_wb_regdst", 32'(RegDst), 32'd1);
        cyc();
        chk("lui_retired", retired, 32'd7);

        // Counter wrap on the 4-bit instance
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("wrap_start", 32'(retired4), 32'd0);
        for (int i = 0; i < 16; i++) begin
            fetch(6'h00, 6'h00);
            chk("nop_pc_we", 32'(pc_we), 32'd1);
            cyc();
            if (i == 14) chk("wrap_15", 32'(retired4), 32'd15);
        end
        chk("wrap_to_zero", 32'(retired4), 32'd0);
        chk("wrap_wide_16", retired, 32'd16);

        // Reset while lw is stalled in MEM
        dm_ready = 1'b0;
        fetch(6'h23, 6'h00);
        cyc();
        cyc();
        chk("lw_mem_state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        chk("lw_rst_regwrite", 32'(RegWrite), 32'd0);
        chk("lw_rst_pc_we", 32'(pc_we), 32'd0);
        cyc();
        reset = 1'b0;
        im_ready = 1'b0;
        dm_ready = 1'b1;
        #1;
        chk("lw_rst_state", 32'(state), 32'd0);
        chk("lw_rst_retired", retired, 32'd0);
        chk("lw_rst_no_regwrite", 32'(RegWrite), 32'd0);

        // Reset while sw is stalled in MEM: MemWrite drops in the reset cycle
        im_ready = 1'b1;
        dm_ready = 1'b0;
        fetch(6'h2B, 6'h00);
        cyc();
        cyc();
        chk("sw_mem_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("sw_rst_state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
